alu_pipe: RTL and testbench

Parametrised, pipelined successor to the 8-bit accumulator ALU for the RISC CPU datapath. It accepts one operation per cycle through a valid/ready handshake, computes the result for the same 3-bit `opcode_t` set, and adds carry/overflow flags, optional saturating add, and a 2-entry output buffer so the downstream stage can stall without losing results. It sits between the accumulator/operand mux and the accumulator write-back/branch logic.

---
 rtl/alu_pipe_if.sv | 30 +++
 rtl/alu_pipe.sv | 106 ++++++++++
 tb/tb_alu_pipe.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// alu_pipe handshake bundle: operation in, buffered result out.
// master drives operations and takes results; slave is the ALU.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] accum;
   logic [WIDTH-1:0] data;
   logic [2:0]       opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             zero;
   logic             carry;
   logic             ovf;
   logic [15:0]      done_cnt;

   modport master (
      output in_valid, accum, data, opcode, out_ready,
      input  in_ready, out_valid, out, zero, carry, ovf,
      input  done_cnt
   );

   modport slave (
      input  in_valid, accum, data, opcode, out_ready,
      output in_ready, out_valid, out, zero, carry, ovf,
      output done_cnt
   );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined accumulator ALU with carry/overflow flags,
// optional saturating add and a 2-entry result buffer.
module alu_pipe #(
   parameter int WIDTH   = 8,
   parameter bit SAT_ADD = 1'b0
) (
   input logic      clk,
   input logic      rst,
   alu_pipe_if.slave bus
);

   typedef enum logic [2:0] {
      OP_HLT = 3'b000,
      OP_SKZ = 3'b001,
      OP_ADD = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_LDA = 3'b101,
      OP_STO = 3'b110,
      OP_JMP = 3'b111
   } opcode_t;

   localparam int EW = WIDTH + 3;

   opcode_t          op;
   logic [WIDTH:0]   sum;
   logic             add_c;
   logic             add_v;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_v;
   logic [EW-1:0]    wdata;

   logic [EW-1:0]    mem [2];
   logic             head;
   logic             tail;
   logic [1:0]       count;
   logic [15:0]      done;
   logic [EW-1:0]    head_e;
   logic             accept;
   logic             pop;

   assign op = opcode_t'(bus.opcode);

   // Result and flags for the operation presented this cycle.
   always_comb begin
      sum   = {1'b0, bus.data} + {1'b0, bus.accum};
      add_c = sum[WIDTH];
      add_v = (bus.data[WIDTH-1] == bus.accum[WIDTH-1])
           && (sum[WIDTH-1] != bus.accum[WIDTH-1]);
      res   = bus.accum;
      res_c = 1'b0;
      res_v = 1'b0;
      unique case (1'b1)
         (op == OP_ADD): begin
            res   = (SAT_ADD && add_c) ? '1
                                       : sum[WIDTH-1:0];
            res_c = add_c;
            res_v = add_v;
         end
         (op == OP_AND): res = bus.data & bus.accum;
         (op == OP_XOR): res = bus.data ^ bus.accum;
         (op == OP_LDA): res = bus.data;
         default:        res = bus.accum;
      endcase
      wdata = {res, (bus.accum == '0), res_c, res_v};
   end

   assign accept = bus.in_valid && bus.in_ready;
   assign pop    = bus.out_valid && bus.out_ready;

   // Result buffer: write at tail on accept, advance head on pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
         done  <= 16'd0;
      end else begin
         if (accept) begin
            mem[tail] <= wdata;
            tail      <= ~tail;
         end
         if (pop) begin
            head <= ~head;
            done <= done + 16'd1;
         end
         unique case ({accept, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head_e       = mem[head];
   assign bus.in_ready = !rst && (count < 2'd2);
   assign bus.out_valid = (count != 2'd0);
   assign bus.out   = bus.out_valid ? head_e[EW-1:3] : '0;
   assign bus.zero  = bus.out_valid && head_e[2];
   assign bus.carry = bus.out_valid && head_e[1];
   assign bus.ovf   = bus.out_valid && head_e[0];
   assign bus.done_cnt = done;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: 8-bit wrap, 8-bit
// saturating and 16-bit instances share clock and reset.
module tb_alu_pipe;

   localparam logic [2:0] HLT = 3'b000;
   localparam logic [2:0] SKZ = 3'b001;
   localparam logic [2:0] ADD = 3'b010;
   localparam logic [2:0] AND = 3'b011;
   localparam logic [2:0] XOR = 3'b100;
   localparam logic [2:0] LDA = 3'b101;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   logic [18:0] q8 [$];
   logic [18:0] qs [$];
   logic [18:0] q16 [$];

   alu_pipe_if #(.WIDTH(8))  b8 ();
   alu_pipe_if #(.WIDTH(8))  bs ();
   alu_pipe_if #(.WIDTH(16)) b16 ();

   alu_pipe #(.WIDTH(8), .SAT_ADD(1'b0)) u8 (
      .clk(clk), .rst(rst), .bus(b8.slave));
   alu_pipe #(.WIDTH(8), .SAT_ADD(1'b1)) us (
      .clk(clk), .rst(rst), .bus(bs.slave));
   alu_pipe #(.WIDTH(16), .SAT_ADD(1'b0)) u16 (
      .clk(clk), .rst(rst), .bus(b16.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [18:0] e(
      logic [15:0] o, logic z, logic c, logic v);
      return {o, z, c, v};
   endfunction

   function automatic logic [18:0] model8(
      logic [2:0] op, logic [7:0] a, logic [7:0] d);
      logic [8:0] s;
      logic [7:0] r;
      logic c;
      logic v;
      s = {1'b0, a} + {1'b0, d};
      c = 1'b0;
      v = 1'b0;
      case (op)
         ADD: begin
            r = s[7:0];
            c = s[8];
            v = (a[7] == d[7]) && (s[7] != a[7]);
         end
         AND:     r = a & d;
         XOR:     r = a ^ d;
         LDA:     r = d;
         default: r = a;
      endcase
      return e({8'h00, r}, a == 8'h00, c, v);
   endfunction

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic rdy(int sel);
      case (sel)
         0:       return b8.in_ready;
         1:       return bs.in_ready;
         default: return b16.in_ready;
      endcase
   endfunction

   task automatic drive(int sel, logic [2:0] op,
      logic [15:0] a, logic [15:0] d, logic [18:0] x);
      case (sel)
         0: begin
            b8.opcode = op; b8.accum = a[7:0];
            b8.data = d[7:0]; b8.in_valid = 1'b1;
            q8.push_back(x);
         end
         1: begin
            bs.opcode = op; bs.accum = a[7:0];
            bs.data = d[7:0]; bs.in_valid = 1'b1;
            qs.push_back(x);
         end
         default: begin
            b16.opcode = op; b16.accum = a;
            b16.data = d; b16.in_valid = 1'b1;
            q16.push_back(x);
         end
      endcase
   endtask

   task automatic acc(int sel);
      logic r;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         r = rdy(sel);
         @(posedge clk);
         #1;
         ok = r;
      end
      case (sel)
         0:       b8.in_valid = 1'b0;
         1:       bs.in_valid = 1'b0;
         default: b16.in_valid = 1'b0;
      endcase
      if (!ok) begin
         checks++;
         errors++;
         $error("FAIL accept_timeout sel %0d got 0 exp 1", sel);
         case (sel)
            0:       void'(q8.pop_back());
            1:       void'(qs.pop_back());
            default: void'(q16.pop_back());
         endcase
      end
   endtask

   task automatic send(int sel, logic [2:0] op,
      logic [15:0] a, logic [15:0] d, logic [18:0] x);
      drive(sel, op, a, d, x);
      acc(sel);
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pop-side scoreboard: compare each consumed head entry.
   always @(negedge clk) begin
      logic [18:0] got;
      logic [18:0] exp;
      if (!rst) begin
         if (b8.out_valid && b8.out_ready) begin
            checks++;
            got = {8'h00, b8.out, b8.zero, b8.carry, b8.ovf};
            if (q8.size() == 0) begin
               errors++;
               $error("FAIL sb8 got %h exp none", got);
            end else begin
               exp = q8.pop_front();
               assert (got === exp) else begin
                  errors++;
                  $error("FAIL sb8 got %h exp %h", got, exp);
               end
            end
         end
         if (bs.out_valid && bs.out_ready) begin
            checks++;
            got = {8'h00, bs.out, bs.zero, bs.carry, bs.ovf};
            if (qs.size() == 0) begin
               errors++;
               $error("FAIL sbs got %h exp none", got);
            end else begin
               exp = qs.pop_front();
               assert (got === exp) else begin
                  errors++;
                  $error("FAIL sbs got %h exp %h", got, exp);
               end
            end
         end
         if (b16.out_valid && b16.out_ready) begin
            checks++;
            got = {b16.out, b16.zero, b16.carry, b16.ovf};
            if (q16.size() == 0) begin
               errors++;
               $error("FAIL sb16 got %h exp none", got);
            end else begin
               exp = q16.pop_front();
               assert (got === exp) else begin
                  errors++;
                  $error("FAIL sb16 got %h exp %h", got, exp);
               end
            end
         end
      end
   end

   initial begin
      int c0;
      logic [15:0] d0;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] d;

      rst = 1'b1;
      b8.in_valid = 0;  b8.out_ready = 0;
      bs.in_valid = 0;  bs.out_ready = 0;
      b16.in_valid = 0; b16.out_ready = 0;
      b8.opcode = HLT;  b8.accum = 0;  b8.data = 0;
      bs.opcode = HLT;  bs.accum = 0;  bs.data = 0;
      b16.opcode = HLT; b16.accum = 0; b16.data = 0;
      idle(2);
      chk("rst_in_ready", b8.in_ready, 0);
      chk("rst_out_valid", b8.out_valid, 0);
      chk("rst_out", b8.out, 0);
      chk("rst_done", b8.done_cnt, 0);
      chk("rst16_in_ready", b16.in_ready, 0);

      rst = 1'b0;
      #1;
      chk("rel_in_ready", b8.in_ready, 1);
      chk("rel_out_valid", b8.out_valid, 0);
      b8.out_ready = 1; bs.out_ready = 1; b16.out_ready = 1;
      idle(1);

      send(0, ADD, 16'h70, 16'h20, e(16'h90, 0, 0, 1));
      send(0, ADD, 16'hF0, 16'h20, e(16'h10, 0, 1, 0));
      send(0, LDA, 16'h33, 16'h5A, e(16'h5A, 0, 0, 0));
      send(0, SKZ, 16'h00, 16'h77, e(16'h00, 1, 0, 0));
      idle(3);
      chk("dir_q_empty", q8.size(), 0);
      chk("dir_done", b8.done_cnt, 4);

      b8.out_ready = 0;
      send(0, XOR, 16'h0F, 16'hFF, e(16'hF0, 0, 0, 0));
      send(0, AND, 16'h3C, 16'hF0, e(16'h30, 0, 0, 0));
      chk("bp_in_ready_low", b8.in_ready, 0);
      chk("bp_out_valid", b8.out_valid, 1);
      chk("bp_head", b8.out, 8'hF0);
      drive(0, ADD, 16'h01, 16'h01, e(16'h02, 0, 0, 0));
      repeat (3) begin
         idle(1);
         chk("bp_hold", b8.out, 8'hF0);
         chk("bp_blocked", b8.in_ready, 0);
      end
      b8.out_ready = 1;
      acc(0);
      idle(3);
      chk("bp_q_empty", q8.size(), 0);
      chk("bp_done", b8.done_cnt, 7);

      c0 = cyc;
      d0 = b8.done_cnt;
      for (int i = 0; i < 100; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = 8'($urandom);
         d  = 8'($urandom);
         if (i == 5) a = 8'h00;
         send(0, op, {8'h00, a}, {8'h00, d},
              model8(op, a, d));
      end
      chk("str_cycles", cyc - c0, 100);
      idle(3);
      chk("str_done", 16'(b8.done_cnt - d0), 100);
      chk("str_q_empty", q8.size(), 0);

      send(1, ADD, 16'hF0, 16'h20, e(16'hFF, 0, 1, 0));
      send(1, ADD, 16'h10, 16'h20, e(16'h30, 0, 0, 0));
      send(2, ADD, 16'hFFFF, 16'h0001, e(16'h0000, 0, 1, 0));
      send(2, AND, 16'h1234, 16'h00FF, e(16'h0034, 0, 0, 0));
      idle(3);
      chk("sat_done", bs.done_cnt, 2);
      chk("w16_done", b16.done_cnt, 2);
      chk("sat_q_empty", qs.size(), 0);
      chk("w16_q_empty", q16.size(), 0);

      b8.out_ready = 0;
      send(0, LDA, 16'h00, 16'hA5, e(16'hA5, 1, 0, 0));
      send(0, XOR, 16'h11, 16'h22, e(16'h33, 0, 0, 0));
      chk("ar_full_valid", b8.out_valid, 1);
      chk("ar_full_ready", b8.in_ready, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", b8.out_valid, 0);
      chk("ar_out", b8.out, 0);
      chk("ar_flags", {b8.zero, b8.carry, b8.ovf}, 0);
      chk("ar_done", b8.done_cnt, 0);
      chk("ar_in_ready", b8.in_ready, 0);
      q8.delete();
      b8.out_ready = 1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("ar_rel_ready", b8.in_ready, 1);
      idle(1);
      chk("ar_post_valid", b8.out_valid, 0);
      chk("ar_post_done", b8.done_cnt, 0);
      chk("ar_post_ready", b8.in_ready, 1);

      idle(3);
      chk("end_q_empty", q8.size() + qs.size() + q16.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
